// File: rtl/fir_stream_pkg.sv
// -----------------------------------------------------------------------------
// fir_stream_pkg
//   Shared types for the FIR Avalon-ST output path.
//   - FIR_DATA_W         : default sample width
//   - PKT_CNT_W          : width of the delivered-packet counter
//   - fir_beat_t         : one stored beat {sop, eop, data}
//   - fir_framer_state_t : write-side packet framer state
// -----------------------------------------------------------------------------
package fir_stream_pkg;

   localparam int FIR_DATA_W = 32;
   localparam int PKT_CNT_W  = 16;

   typedef struct packed {
      logic                  sop;
      logic                  eop;
      logic [FIR_DATA_W-1:0] data;
   } fir_beat_t;

   typedef enum logic {
      FR_IDLE   = 1'b0,
      FR_IN_PKT = 1'b1
   } fir_framer_state_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// -----------------------------------------------------------------------------
// fir_sync_fifo
//   Generic single-clock show-ahead FIFO. The head entry is always presented on
//   pop_data; pop consumes it. Count is derived from the pointer difference so
//   full and empty are unambiguous with DEPTH a power of two.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (pointers cleared)
//   push       : write push_data this cycle (ignored when full unless popping)
//   push_data  : entry to write
//   pop        : consume the head entry (ignored when empty)
//   pop_data   : head entry (undefined contents when empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fir_sync_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // A push at full is legal when the head is leaving in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fir_source_buffer.sv
// -----------------------------------------------------------------------------
// fir_source_buffer
//   Output stage of the FIR Avalon-ST path. Beats arrive from the sideband
//   delay pipeline and cannot be stalled, so they are framed, buffered in a
//   show-ahead FIFO and presented on a backpressurable source. sink_ready is
//   generated with enough headroom for the PIPE_LAT beats already in flight.
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data/valid/sop/eop : delayed beat from the pipeline (never refused)
//   sink_ready            : registered ready returned upstream
//   source_data/valid/sop/eop, source_ready : Avalon-ST source, readyLatency 0
//   err_clear             : pulse clearing the sticky error flags
//   overflow_err          : sticky, a framed beat found the FIFO full
//   framing_err           : sticky, SOP inside a packet or beat outside one
//   pkt_count             : EOP beats accepted at the source, wrapping
//
// Handshake: a source transfer happens on a clk edge where source_valid and
// source_ready are both 1. While source_valid=1 and source_ready=0 the head
// entry is held, so data/sop/eop stay stable. source_valid never depends on
// source_ready. Upstream, sink_ready in cycle c permits one beat to arrive
// here PIPE_LAT cycles later; in_valid itself is always taken.
// -----------------------------------------------------------------------------
module fir_source_buffer
   import fir_stream_pkg::*;
#(
   parameter int DATA_W   = FIR_DATA_W,
   parameter int DEPTH    = 16,
   parameter int PIPE_LAT = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   input  logic                  in_sop,
   input  logic                  in_eop,
   output logic                  sink_ready,
   output logic [DATA_W-1:0]     source_data,
   output logic                  source_valid,
   output logic                  source_sop,
   output logic                  source_eop,
   input  logic                  source_ready,
   input  logic                  err_clear,
   output logic                  overflow_err,
   output logic                  framing_err,
   output logic [PKT_CNT_W-1:0]  pkt_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] READY_MIN_C = CNT_W'(PIPE_LAT + 2);

   // Elaboration-time parameter checks.
   if (DEPTH < PIPE_LAT + 3) begin : g_depth_too_small
      $error("fir_source_buffer: DEPTH must be >= PIPE_LAT+3");
   end
   if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_not_pow2
      $error("fir_source_buffer: DEPTH must be a power of two");
   end
   if (DATA_W != FIR_DATA_W) begin : g_width_mismatch
      $error("fir_source_buffer: DATA_W must equal fir_stream_pkg::FIR_DATA_W");
   end

   fir_framer_state_t state_q;
   fir_framer_state_t state_d;

   fir_beat_t        wr_beat;
   fir_beat_t        rd_beat;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   logic             frame_ok;
   logic             frame_err_new;
   logic             ovf_new;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] free_nxt;
   logic             ready_nxt;

   // ---------------------------------------------------------------- framer
   // frame_ok marks a beat that belongs to a packet and may be stored. An SOP
   // inside a packet is flagged but still stored as the start of a new packet.
   always_comb begin
      state_d       = state_q;
      frame_ok      = 1'b0;
      frame_err_new = 1'b0;
      if (in_valid) begin
         case (state_q)
            FR_IDLE: begin
               if (in_sop) begin
                  frame_ok = 1'b1;
                  state_d  = in_eop ? FR_IDLE : FR_IN_PKT;
               end else begin
                  frame_err_new = 1'b1;
               end
            end
            FR_IN_PKT: begin
               frame_ok = 1'b1;
               if (in_sop) frame_err_new = 1'b1;
               if (in_eop) state_d = FR_IDLE;
            end
            default: state_d = FR_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FR_IDLE;
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------------ FIFO
   assign pop     = !fifo_empty && source_ready;
   assign push    = frame_ok && (!fifo_full || pop);
   assign ovf_new = frame_ok && fifo_full && !pop;

   assign wr_beat.sop  = in_sop;
   assign wr_beat.eop  = in_eop;
   assign wr_beat.data = in_data;

   fir_sync_fifo #(
      .WIDTH ($bits(fir_beat_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (wr_beat),
      .pop       (pop),
      .pop_data  (rd_beat),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Outputs are forced to zero while empty so nothing stale is visible.
   assign source_valid = !fifo_empty;
   assign source_data  = fifo_empty ? '0   : rd_beat.data;
   assign source_sop   = fifo_empty ? 1'b0 : rd_beat.sop;
   assign source_eop   = fifo_empty ? 1'b0 : rd_beat.eop;

   // ----------------------------------------------------------------- ready
   // Free space after this cycle's push/pop must cover the register cycle
   // plus PIPE_LAT beats that may already be travelling down the pipeline.
   assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
   assign free_nxt  = DEPTH_C - count_nxt;
   assign ready_nxt = (free_nxt >= READY_MIN_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sink_ready <= 1'b0;
      else        sink_ready <= ready_nxt;
   end

   // ------------------------------------------------- errors and pkt counter
   // A clear and a new error in the same cycle leaves the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_err <= 1'b0;
         framing_err  <= 1'b0;
         pkt_count    <= '0;
      end else begin
         overflow_err <= (overflow_err && !err_clear) || ovf_new;
         framing_err  <= (framing_err  && !err_clear) || frame_err_new;
         if (pop && rd_beat.eop) pkt_count <= pkt_count + 1'b1;
      end
   end

endmodule
